grf_wb_arbiter: RTL and testbench
=================================

# grf_wb_arbiter

Write-back arbiter for the GRF's single write port. Shares the port between the in-order pipeline W stage (requester 0, never stalled) and a slow-result requester (requester 1: multi-cycle load return / MDU move-from path) that uses a valid/ready handshake into a small FIFO. Drives the GRF write inputs (`RegWrite`, `rtd`, `busW`, `PC4`) from registers. Provides pending-write hazard flags and a starvation stall request to the pipeline controller.

## Interface
- `DEPTH`, 2: requester-1 FIFO entries; power of two, at least 2.
- `STARVE_LIMIT`, 8: consecutive cycles a live FIFO head may wait before `stall_req` asserts; at least 1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- `p0_we`  in  1  pipeline W-stage write request.
- `p0_addr`  in  5  destination register.
- `p0_data`  in  32  write data.
- `p0_pc`  in  32  PC of the writing instruction, passed to `PC4`.
- `p1_valid`  in  1  requester-1 write offered.
- `p1_ready`  out  1  FIFO can accept: `count < DEPTH`; independent of `p1_valid`.
- `p1_addr`, `p1_data`, `p1_pc`  in  5/32/32  requester-1 payload.
- `rs`, `rt`  in  5  hazard query addresses from D stage.
- `hit_rs`, `hit_rt`  out  1  query register has a pending write: a live FIFO entry or the output stage.
- `stall_req`  out  1  registered; pipeline must hold `p0_we` low while high.
- `count`  out  $clog2(DEPTH)+1  occupied FIFO slots, live or dead.
- `RegWrite`  out  1  GRF write enable.
- `rtd`  out  5  GRF write address.
- `busW`  out  32  GRF write data.
- `PC4`  out  32  PC of the committed write.

## Operation
- Handshake: a p1 transfer occurs on a rising edge when `p1_valid && p1_ready`. Payload is sampled at that edge. `p1_addr == 0` transfers are accepted and discarded.
- `p0_we` with `p0_addr == 0` counts as no request.
- Output selection, evaluated every cycle in this priority order:
  1. Real p0 request: output is loaded with the p0 payload.
  2. Else, FIFO non-empty: the head is popped. A live head is loaded to the output. A dead head gives `RegWrite = 0`.
  3. Else, FIFO empty and a p1 transfer occurs: the payload bypasses the FIFO and loads the output directly.
  4. Else: `RegWrite = 0`.
- When `RegWrite = 0`, `rtd`, `busW` and `PC4` hold their previous values.
- In every case except the bypass, an accepted p1 payload is pushed at the tail. Push and pop may happen in the same cycle.
- WAW squash: when a p0 write to register R is granted:
  - every live FIFO entry with address R is marked dead;
  - a p1 payload to R transferring in the same cycle is stored dead.
- Each entry holds a live bit alongside its payload. Dead entries still occupy slots until they are popped.
- Starvation counter:
  - increments each cycle the head is live and not popped;
  - clears on pop or when the FIFO is empty;
  - `stall_req` is registered high when the counter reaches `STARVE_LIMIT` and stays high until the head is popped.
- If `p0_we` is high while `stall_req` is high, p0 still wins. No write is ever dropped.
- `hit_rs` is high when `rs != 0` and `rs` matches a live FIFO entry address, or `RegWrite && rtd == rs`. `hit_rt` uses the same rule with `rt`. Both are combinational from state only.

## Timing
- Reset values: `RegWrite = 0`, `rtd = 0`, `busW = 0`, `PC4 = 0`, `count = 0`, `stall_req = 0`, FIFO empty, starvation counter 0.
  - `p1_ready = 1` while `reset` is low, but no transfer is taken while `reset` is low.
- Reset asserted mid-operation discards all FIFO contents and any pending output write.
- Latency:
  - p0 request → `RegWrite` high the next cycle; the GRF commits on the following edge.
  - p1 into an empty FIFO with p0 idle → output the next cycle.
  - A queued entry pops in the first cycle with no real p0 request.
- Full FIFO: `p1_ready = 0`, even in a cycle where a pop occurs; it rises the cycle after the pop.
- Read and write pointers wrap modulo `DEPTH`. `count` disambiguates full from empty.
- Throughput: at most one GRF write per cycle; p0 at 100% of cycles starves p1 until `stall_req`.

## Test plan
- Reset, then p0 writes 32'h1 to $28 at PC 32'h3000 → next cycle `RegWrite=1`, `rtd=28`, `busW=1`, `PC4=32'h3000`; one cycle later `RegWrite=0`.
- p1 sends $5=32'hAA with the FIFO empty and p0 idle → bypass; output `rtd=5`, `busW=32'hAA` next cycle; `count` stays 0.
- p0 writes every cycle while p1 pushes $6 and $7 (DEPTH=2) → `count=2`, `p1_ready=0`, `hit_rs=1` for `rs=6`; after 8 waiting cycles `stall_req=1`. Then drop `p0_we` → $6 then $7 written on consecutive cycles; `stall_req` clears after the $6 pop.
- FIFO holds live $9, then p0 writes $9=32'h55 → the entry goes dead; the later pop shows `RegWrite=0`; the GRF is last written with 32'h55.
- p1 and p0 both target $3 in the same cycle with the FIFO empty → p0 written; the p1 entry is stored dead; no second write to $3.
- Assert `reset` low asynchronously with `count=2` and `RegWrite=1` → all outputs return to reset values before the next clock edge; `hit_rs=0` and `hit_rt=0` for all queries.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter for the GRF's single write port: pipeline W stage (p0) has
// priority, slow results (p1) queue in a small FIFO with WAW squash and starvation stall.
module grf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p0_we,
    input  logic [4:0]               p0_addr,
    input  logic [31:0]              p0_data,
    input  logic [31:0]              p0_pc,
    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic [4:0]               p1_addr,
    input  logic [31:0]              p1_data,
    input  logic [31:0]              p1_pc,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     hit_rs,
    output logic                     hit_rt,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     RegWrite,
    output logic [4:0]               rtd,
    output logic [31:0]              busW,
    output logic [31:0]              PC4
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_t;

    wb_t            mem_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           stall_q, stall_d;
    logic           out_we_q, out_we_d;
    wb_t            out_q, out_d;

    logic p0_req, p1_take, empty, pop, bypass, push, head_live;
    wb_t  p0_pay, p1_pay;

    assign p0_pay    = '{addr: p0_addr, data: p0_data, pc: p0_pc};
    assign p1_pay    = '{addr: p1_addr, data: p1_data, pc: p1_pc};
    assign p0_req    = p0_we && (p0_addr != 5'd0);
    assign p1_ready  = (count_q < CW'(DEPTH));
    // Writes to $0 complete the handshake but leave no trace.
    assign p1_take   = p1_valid && p1_ready && (p1_addr != 5'd0);
    assign empty     = (count_q == '0);
    assign pop       = !p0_req && !empty;
    assign bypass    = !p0_req && empty && p1_take;
    assign push      = p1_take && !bypass;
    assign head_live = live_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        live_d   = live_q;
        out_we_d = 1'b0;
        out_d    = out_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (p0_req) begin
            out_we_d = 1'b1;
            out_d    = p0_pay;
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && (mem_q[i].addr == p0_addr)) live_d[i] = 1'b0;
            end
        end else if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + AW'(1);
            if (head_live) begin
                out_we_d = 1'b1;
                out_d    = mem_q[rd_ptr_q];
            end
        end else if (bypass) begin
            out_we_d = 1'b1;
            out_d    = p1_pay;
        end
        if (push) begin
            live_d[wr_ptr_q] = !(p0_req && (p1_addr == p0_addr));
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (pop || empty)                                starve_d = '0;
        else if (head_live && starve_q < SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
        else                                             starve_d = starve_q;
        stall_d = (pop || empty) ? 1'b0 : (stall_q || (starve_d >= SW'(STARVE_LIMIT)));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            out_we_q <= 1'b0;
            out_q    <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            out_we_q <= out_we_d;
            out_q    <= out_d;
        end
    end

    // NOTE: payload storage is not reset; the live bits alone decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= p1_pay;
    end

    always_comb begin
        hit_rs = out_we_q && (out_q.addr == rs);
        hit_rt = out_we_q && (out_q.addr == rt);
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (mem_q[i].addr == rs)) hit_rs = 1'b1;
            if (live_q[i] && (mem_q[i].addr == rt)) hit_rt = 1'b1;
        end
        if (rs == 5'd0) hit_rs = 1'b0;
        if (rt == 5'd0) hit_rt = 1'b0;
    end

    assign stall_req = stall_q;
    assign count     = count_q;
    assign RegWrite  = out_we_q;
    assign rtd       = out_q.addr;
    assign busW      = out_q.data;
    assign PC4       = out_q.pc;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: a per-cycle vector table plus hand-written
// starvation and asynchronous-reset sequences.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_we;
    logic [4:0]  p0_addr;
    logic [31:0] p0_data, p0_pc;
    logic        p1_valid, p1_ready;
    logic [4:0]  p1_addr;
    logic [31:0] p1_data, p1_pc;
    logic [4:0]  rs, rt;
    logic        hit_rs, hit_rt, stall_req;
    logic [1:0]  count;
    logic        RegWrite;
    logic [4:0]  rtd;
    logic [31:0] busW, PC4;

    int checks = 0;
    int errors = 0;

    grf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .p0_we(p0_we), .p0_addr(p0_addr), .p0_data(p0_data), .p0_pc(p0_pc),
        .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p1_addr(p1_addr), .p1_data(p1_data), .p1_pc(p1_pc),
        .rs(rs), .rt(rt), .hit_rs(hit_rs), .hit_rt(hit_rt),
        .stall_req(stall_req), .count(count),
        .RegWrite(RegWrite), .rtd(rtd), .busW(busW), .PC4(PC4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p0_we;
        logic [4:0]  p0_addr;
        logic [31:0] p0_data, p0_pc;
        logic        p1_valid;
        logic [4:0]  p1_addr;
        logic [31:0] p1_data, p1_pc;
        logic [4:0]  rs, rt;
        logic        e_we;
        logic [4:0]  e_rtd;
        logic [31:0] e_busw, e_pc4;
        int          e_count;
        logic        e_ready, e_hrs, e_hrt, e_stall;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(
        input logic p0w, input logic [4:0] p0a, input logic [31:0] p0d, input logic [31:0] p0p,
        input logic p1v, input logic [4:0] p1a, input logic [31:0] p1d, input logic [31:0] p1p,
        input logic [4:0] qs, input logic [4:0] qt,
        input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p,
        input int c, input logic rdy, input logic hs, input logic ht, input logic st);
        vec_t v;
        v.p0_we = p0w; v.p0_addr = p0a; v.p0_data = p0d; v.p0_pc = p0p;
        v.p1_valid = p1v; v.p1_addr = p1a; v.p1_data = p1d; v.p1_pc = p1p;
        v.rs = qs; v.rt = qt;
        v.e_we = we; v.e_rtd = a; v.e_busw = d; v.e_pc4 = p; v.e_count = c;
        v.e_ready = rdy; v.e_hrs = hs; v.e_hrt = ht; v.e_stall = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_p0(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        p0_we = we; p0_addr = a; p0_data = d; p0_pc = p;
    endtask

    task automatic drive_p1(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        p1_valid = v; p1_addr = a; p1_data = d; p1_pc = p;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] a,
                             input logic [31:0] d, input int c);
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(we));
        check({tag, ".rtd"},      32'(rtd),      32'(a));
        check({tag, ".busW"},     busW,          d);
        check({tag, ".count"},    32'(count),    32'(c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            p0: we addr data        pc            p1: v addr data      pc          rs  rt   exp: we rtd busw       pc4      cnt rdy hrs hrt stall
        vecs[0]  = mk(1, 28, 32'h1,   32'h3000, 0, 0,  32'h0,   32'h0,    28, 0,  1, 28, 32'h1,  32'h3000, 0, 1, 1, 0, 0);
        vecs[1]  = mk(0, 0,  32'h0,   32'h0,    0, 0,  32'h0,   32'h0,    28, 0,  0, 28, 32'h1,  32'h3000, 0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0,  32'h0,   32'h0,    1, 5,  32'hAA,  32'h3004, 5,  0,  1, 5,  32'hAA, 32'h3004, 0, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0,  32'h0,   32'h0,    0, 0,  32'h0,   32'h0,    5,  0,  0, 5,  32'hAA, 32'h3004, 0, 1, 0, 0, 0);
        vecs[4]  = mk(1, 10, 32'h11,  32'h3008, 1, 9,  32'h99,  32'h300C, 9,  10, 1, 10, 32'h11, 32'h3008, 1, 1, 1, 1, 0);
        vecs[5]  = mk(1, 9,  32'h55,  32'h3010, 0, 0,  32'h0,   32'h0,    9,  10, 1, 9,  32'h55, 32'h3010, 1, 1, 1, 0, 0);
        vecs[6]  = mk(0, 0,  32'h0,   32'h0,    0, 0,  32'h0,   32'h0,    9,  10, 0, 9,  32'h55, 32'h3010, 0, 1, 0, 0, 0);
        vecs[7]  = mk(1, 3,  32'h33,  32'h3014, 1, 3,  32'h77,  32'h3018, 3,  3,  1, 3,  32'h33, 32'h3014, 1, 1, 1, 1, 0);
        vecs[8]  = mk(0, 0,  32'h0,   32'h0,    0, 0,  32'h0,   32'h0,    3,  3,  0, 3,  32'h33, 32'h3014, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0,  32'h0,   32'h0,    1, 0,  32'hF0,  32'h30FC, 0,  3,  0, 3,  32'h33, 32'h3014, 0, 1, 0, 0, 0);
        vecs[10] = mk(1, 0,  32'hBAD, 32'h30F0, 1, 12, 32'hC,   32'h301C, 12, 0,  1, 12, 32'hC,  32'h301C, 0, 1, 1, 0, 0);
        vecs[11] = mk(1, 1,  32'h1,   32'h3020, 1, 13, 32'hD,   32'h3024, 13, 1,  1, 1,  32'h1,  32'h3020, 1, 1, 1, 1, 0);
        vecs[12] = mk(0, 0,  32'h0,   32'h0,    1, 14, 32'hE,   32'h3028, 14, 13, 1, 13, 32'hD,  32'h3024, 1, 1, 1, 1, 0);
        vecs[13] = mk(0, 0,  32'h0,   32'h0,    0, 0,  32'h0,   32'h0,    14, 0,  1, 14, 32'hE,  32'h3028, 0, 1, 1, 0, 0);
        vecs[14] = mk(0, 0,  32'h0,   32'h0,    0, 0,  32'h0,   32'h0,    14, 0,  0, 14, 32'hE,  32'h3028, 0, 1, 0, 0, 0);

        reset = 1'b0;
        drive_p0(0, 0, 0, 0);
        drive_p1(0, 0, 0, 0);
        rs = 5'd0; rt = 5'd0;
        #2;
        check_out("reset", 0, 0, 32'h0, 0);
        check("reset.PC4",      PC4,              32'h0);
        check("reset.stall",    32'(stall_req),   32'h0);
        check("reset.p1_ready", 32'(p1_ready),    32'h1);
        step();
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            drive_p0(vecs[i].p0_we, vecs[i].p0_addr, vecs[i].p0_data, vecs[i].p0_pc);
            drive_p1(vecs[i].p1_valid, vecs[i].p1_addr, vecs[i].p1_data, vecs[i].p1_pc);
            rs = vecs[i].rs; rt = vecs[i].rt;
            step();
            check($sformatf("vec%0d.RegWrite", i), 32'(RegWrite),  32'(vecs[i].e_we));
            check($sformatf("vec%0d.rtd", i),      32'(rtd),       32'(vecs[i].e_rtd));
            check($sformatf("vec%0d.busW", i),     busW,           vecs[i].e_busw);
            check($sformatf("vec%0d.PC4", i),      PC4,            vecs[i].e_pc4);
            check($sformatf("vec%0d.count", i),    32'(count),     32'(vecs[i].e_count));
            check($sformatf("vec%0d.p1_ready", i), 32'(p1_ready),  32'(vecs[i].e_ready));
            check($sformatf("vec%0d.hit_rs", i),   32'(hit_rs),    32'(vecs[i].e_hrs));
            check($sformatf("vec%0d.hit_rt", i),   32'(hit_rt),    32'(vecs[i].e_hrt));
            check($sformatf("vec%0d.stall", i),    32'(stall_req), 32'(vecs[i].e_stall));
        end

        // Starvation: p0 busy every cycle, $6 and $7 queue up, $8 refused while full.
        rs = 5'd6; rt = 5'd0;
        for (int i = 0; i <= 8; i++) begin
            drive_p0(1, 10, 32'hA0 + i, 32'h4000 + 4 * i);
            if (i == 0)      drive_p1(1, 6, 32'h66, 32'h5000);
            else if (i == 1) drive_p1(1, 7, 32'h77, 32'h5004);
            else if (i == 2) drive_p1(1, 8, 32'h88, 32'h5008);
            else             drive_p1(0, 0, 0, 0);
            step();
            check($sformatf("starve%0d.stall", i), 32'(stall_req), (i >= 8) ? 32'h1 : 32'h0);
            if (i >= 1) begin
                check($sformatf("starve%0d.count", i), 32'(count),    32'h2);
                check($sformatf("starve%0d.ready", i), 32'(p1_ready), 32'h0);
                check($sformatf("starve%0d.hit6", i),  32'(hit_rs),   32'h1);
            end
        end
        drive_p0(1, 10, 32'hB0, 32'h4100);
        step();
        check_out("starve_p0wins", 1, 10, 32'hB0, 2);
        check("starve_p0wins.stall", 32'(stall_req), 32'h1);
        drive_p0(0, 0, 0, 0);
        step();
        check_out("pop6", 1, 6, 32'h66, 1);
        check("pop6.PC4",   PC4,              32'h5000);
        check("pop6.stall", 32'(stall_req),   32'h0);
        check("pop6.ready", 32'(p1_ready),    32'h1);
        step();
        check_out("pop7", 1, 7, 32'h77, 0);
        step();
        check_out("idle_after_pops", 0, 7, 32'h77, 0);

        // Asynchronous reset mid-operation with a full FIFO and a pending write.
        drive_p0(1, 10, 32'hC0, 32'h6000);
        drive_p1(1, 6, 32'h66, 32'h6004);
        step();
        drive_p1(1, 7, 32'h77, 32'h6008);
        step();
        check_out("prereset", 1, 10, 32'hC0, 2);
        drive_p1(1, 5, 32'h55, 32'h600C);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 32'h0, 0);
        check("async_reset.PC4",   PC4,            32'h0);
        check("async_reset.stall", 32'(stall_req), 32'h0);
        check("async_reset.ready", 32'(p1_ready),  32'h1);
        for (int a = 0; a < 32; a++) begin
            rs = 5'(a); rt = 5'(31 - a);
            #0.1;
            check($sformatf("async_reset.hit_rs%0d", a), 32'(hit_rs), 32'h0);
            check($sformatf("async_reset.hit_rt%0d", a), 32'(hit_rt), 32'h0);
        end
        @(posedge clk);
        #1;
        check_out("held_reset", 0, 0, 32'h0, 0);
        drive_p0(0, 0, 0, 0);
        drive_p1(0, 0, 0, 0);
        reset = 1'b1;
        step();
        check_out("post_reset", 0, 0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
